// File: rtl/pre_load_pkg.sv
// pre_load_pkg: shared state encoding, tile constants and data widths for the pre-load sequencer
package pre_load_pkg;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
  localparam int ADDR_W = 6;
  localparam int N_WEIGHT = 64;
  localparam int N_ACT = 64;
  localparam int W_DATA = 8;
  localparam int A_DATA = 7;
  localparam int CNT_W = max2(ADDR_W, $clog2(max2(N_WEIGHT, N_ACT))) + 1;
  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_A, WAIT_WPU, PRE_CW, CAL} state_t;
endpackage

// File: rtl/preload_sequencer_if.sv
// preload_sequencer_if: host handshake and datapath control bundle of the pre-load sequencer
interface preload_sequencer_if;
  import pre_load_pkg::*;
  logic start;
  logic busy;
  logic done;
  logic w_in_valid;
  logic w_in_ready;
  logic [W_DATA-1:0] w_in_data;
  logic a_in_valid;
  logic a_in_ready;
  logic [A_DATA-1:0] a_in_data;
  logic [W_DATA-1:0] Weight;
  logic [ADDR_W-1:0] Weight_Mem_Address_in;
  logic w_we;
  logic [A_DATA-1:0] Activation;
  logic [ADDR_W-1:0] Activation_Mem_Address_in;
  logic a_we;
  logic load_mem_done;
  logic PreLoad_CWeight;
  logic Cal;
  modport master (
    output start, w_in_valid, w_in_data, a_in_valid, a_in_data,
    input busy, done, w_in_ready, a_in_ready, Weight, Weight_Mem_Address_in, w_we,
    input Activation, Activation_Mem_Address_in, a_we, load_mem_done, PreLoad_CWeight, Cal
  );
  modport slave (
    input start, w_in_valid, w_in_data, a_in_valid, a_in_data,
    output busy, done, w_in_ready, a_in_ready, Weight, Weight_Mem_Address_in, w_we,
    output Activation, Activation_Mem_Address_in, a_we, load_mem_done, PreLoad_CWeight, Cal
  );
endinterface

// File: rtl/stream_writer.sv
// stream_writer: valid/ready sink that registers N beats to sequential addresses with 1-cycle latency
module stream_writer
  import pre_load_pkg::*;
#(
  parameter int DW = 8,
  parameter int N = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_valid,
  input  logic [DW-1:0] i_data,
  output logic o_ready,
  output logic o_last_beat,
  output logic o_we,
  output logic [DW-1:0] o_data,
  output logic [ADDR_W-1:0] o_addr
);
  localparam int CW = $clog2(N) + 1;
  logic [CW-1:0] r_cnt;
  logic w_fire;
  assign o_ready = i_en && (r_cnt < CW'(N));
  assign w_fire = i_valid && o_ready;
  assign o_last_beat = w_fire && (r_cnt == CW'(N - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      o_we <= 1'b0;
      o_data <= '0;
      o_addr <= '0;
    end else begin
      o_we <= w_fire;
      r_cnt <= i_en ? r_cnt + CW'(w_fire) : '0;
      if (w_fire) begin
        o_data <= i_data;
        o_addr <= r_cnt[ADDR_W-1:0];
      end
    end
  end
endmodule

// File: rtl/preload_sequencer.sv
// preload_sequencer: loads a weight/activation tile, then runs the WPU wait, CW preload and Cal schedule
module preload_sequencer
  import pre_load_pkg::*;
#(
  parameter int WPU_WAIT = 64,
  parameter int CW_CYCLES = 3,
  parameter int CAL_CYCLES = 22
) (
  input logic clk,
  input logic rst,
  preload_sequencer_if.slave bus
);
  // WAIT_WPU lasts one extra cycle so load_mem_done, which lags the state by one, is held WPU_WAIT cycles
  localparam logic [CNT_W-1:0] WAIT_END = CNT_W'(WPU_WAIT);
  localparam logic [CNT_W-1:0] CW_END = CNT_W'(CW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CAL_END = CNT_W'(CAL_CYCLES - 1);
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic r_load_mem_done;
  logic w_w_last, w_a_last;
  stream_writer #(.DW(W_DATA), .N(N_WEIGHT)) u_w_writer (
    .clk(clk),
    .rst(rst),
    .i_en(r_state == LOAD_W),
    .i_valid(bus.w_in_valid),
    .i_data(bus.w_in_data),
    .o_ready(bus.w_in_ready),
    .o_last_beat(w_w_last),
    .o_we(bus.w_we),
    .o_data(bus.Weight),
    .o_addr(bus.Weight_Mem_Address_in)
  );
  stream_writer #(.DW(A_DATA), .N(N_ACT)) u_a_writer (
    .clk(clk),
    .rst(rst),
    .i_en(r_state == LOAD_A),
    .i_valid(bus.a_in_valid),
    .i_data(bus.a_in_data),
    .o_ready(bus.a_in_ready),
    .o_last_beat(w_a_last),
    .o_we(bus.a_we),
    .o_data(bus.Activation),
    .o_addr(bus.Activation_Mem_Address_in)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = bus.start ? LOAD_W : IDLE;
      LOAD_W:   w_next = w_w_last ? LOAD_A : LOAD_W;
      LOAD_A:   w_next = w_a_last ? WAIT_WPU : LOAD_A;
      WAIT_WPU: w_next = (r_cnt == WAIT_END) ? PRE_CW : WAIT_WPU;
      PRE_CW:   w_next = (r_cnt == CW_END) ? CAL : PRE_CW;
      CAL:      w_next = (r_cnt == CAL_END) ? IDLE : CAL;
      default:  w_next = IDLE;
    endcase
  end
  assign bus.busy = r_state != IDLE;
  assign bus.PreLoad_CWeight = r_state == PRE_CW;
  assign bus.Cal = r_state == CAL;
  assign bus.done = (r_state == CAL) && (r_cnt == CAL_END);
  assign bus.load_mem_done = r_load_mem_done;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_load_mem_done <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt <= (w_next != r_state) ? '0 : r_cnt + CNT_W'(1);
      r_load_mem_done <= (r_state inside {WAIT_WPU, PRE_CW, CAL}) && (w_next != IDLE);
    end
  end
endmodule

// File: tb/tb_preload_sequencer.sv
// tb_preload_sequencer: directed self-checking bench for the pre-load sequencer
module tb_preload_sequencer;
  import pre_load_pkg::*;
  typedef struct {
    int off;
    bit lmd;
    bit pcw;
    bit cal;
    bit done;
    bit busy;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int n_w = 0;
  int n_a = 0;
  int n_done = 0;
  int n_rdy_ovl = 0;
  int n_phase_ovl = 0;
  vec_t tbl[10];
  preload_sequencer_if bus();
  preload_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [6:0] a_pat(input int i);
    return 7'((i * 3 + 1) & 127);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_w_ready"}, 32'(bus.w_in_ready), 0);
    chk({tag, "_a_ready"}, 32'(bus.a_in_ready), 0);
    chk({tag, "_weight"}, 32'(bus.Weight), 0);
    chk({tag, "_w_addr"}, 32'(bus.Weight_Mem_Address_in), 0);
    chk({tag, "_w_we"}, 32'(bus.w_we), 0);
    chk({tag, "_act"}, 32'(bus.Activation), 0);
    chk({tag, "_a_addr"}, 32'(bus.Activation_Mem_Address_in), 0);
    chk({tag, "_a_we"}, 32'(bus.a_we), 0);
    chk({tag, "_lmd"}, 32'(bus.load_mem_done), 0);
    chk({tag, "_pcw"}, 32'(bus.PreLoad_CWeight), 0);
    chk({tag, "_cal"}, 32'(bus.Cal), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.w_we) begin
        chk("w_addr", 32'(bus.Weight_Mem_Address_in), 32'(n_w));
        chk("w_data", 32'(bus.Weight), 32'(n_w & 255));
        n_w++;
      end
      if (bus.a_we) begin
        chk("a_addr", 32'(bus.Activation_Mem_Address_in), 32'(n_a));
        chk("a_data", 32'(bus.Activation), 32'(a_pat(n_a)));
        n_a++;
      end
      if (bus.done) n_done++;
      if (bus.w_in_ready && bus.a_in_ready) n_rdy_ovl++;
      if (bus.Cal && bus.PreLoad_CWeight) n_phase_ovl++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit is_a, input int i, input int bub);
    int guard;
    bit acc;
    guard = 0;
    acc = 1'b0;
    do begin
      if (is_a) begin
        bus.a_in_valid = ($urandom_range(99) >= bub);
        bus.a_in_data = a_pat(i);
      end else begin
        bus.w_in_valid = ($urandom_range(99) >= bub);
        bus.w_in_data = 8'(i);
      end
      #3;
      acc = is_a ? (bus.a_in_valid && bus.a_in_ready) : (bus.w_in_valid && bus.w_in_ready);
      tick();
      guard++;
    end while (!acc && guard < 500);
    if (!acc) begin
      errors++;
      $display("FAIL handshake_timeout: beat %0d channel %0d not accepted", i, is_a);
      $fatal(1, "handshake timeout");
    end
  endtask

  task automatic start_tile();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic load_weights(input int bub, input bit hold_w);
    for (int i = 0; i < N_WEIGHT; i++) send(1'b0, i, bub);
    bus.w_in_valid = hold_w;
    bus.w_in_data = 8'hEE;
    chk("w_ready_after_last", 32'(bus.w_in_ready), 0);
    chk("a_ready_in_load_a", 32'(bus.a_in_ready), 1);
    chk("w_we_last", 32'(bus.w_we), 1);
    chk("w_addr_last", 32'(bus.Weight_Mem_Address_in), 63);
  endtask

  task automatic phase_check(input bit pulse_start);
    int pcw_n;
    int cal_n;
    pcw_n = 0;
    cal_n = 0;
    for (int off = -1; off <= 95; off++) begin
      if (bus.PreLoad_CWeight) pcw_n++;
      if (bus.Cal) cal_n++;
      for (int k = 0; k < 10; k++) begin
        if (tbl[k].off == off) begin
          chk($sformatf("lmd@%0d", off), 32'(bus.load_mem_done), 32'(tbl[k].lmd));
          chk($sformatf("pcw@%0d", off), 32'(bus.PreLoad_CWeight), 32'(tbl[k].pcw));
          chk($sformatf("cal@%0d", off), 32'(bus.Cal), 32'(tbl[k].cal));
          chk($sformatf("done@%0d", off), 32'(bus.done), 32'(tbl[k].done));
          chk($sformatf("busy@%0d", off), 32'(bus.busy), 32'(tbl[k].busy));
        end
      end
      bus.start = pulse_start && (off == 70 || off == 88);
      tick();
    end
    bus.start = 1'b0;
    chk("pcw_cycles", 32'(pcw_n), 3);
    chk("cal_cycles", 32'(cal_n), 22);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{-1, 0, 0, 0, 0, 1};
    tbl[1] = '{0, 1, 0, 0, 0, 1};
    tbl[2] = '{63, 1, 0, 0, 0, 1};
    tbl[3] = '{64, 1, 1, 0, 0, 1};
    tbl[4] = '{66, 1, 1, 0, 0, 1};
    tbl[5] = '{67, 1, 0, 1, 0, 1};
    tbl[6] = '{87, 1, 0, 1, 0, 1};
    tbl[7] = '{88, 1, 0, 1, 1, 1};
    tbl[8] = '{89, 0, 0, 0, 0, 0};
    tbl[9] = '{95, 0, 0, 0, 0, 0};
    bus.start = 1'b0;
    bus.w_in_valid = 1'b0;
    bus.w_in_data = '0;
    bus.a_in_valid = 1'b0;
    bus.a_in_data = '0;
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b0;
    tick();
    chk("idle_no_start_busy", 32'(bus.busy), 0);
    // Tile A: back-to-back beats, weight valid held past the 64th beat, start pulsed in CAL and on done
    start_tile();
    chk("busy_load_w", 32'(bus.busy), 1);
    chk("w_ready_load_w", 32'(bus.w_in_ready), 1);
    chk("a_ready_load_w", 32'(bus.a_in_ready), 0);
    load_weights(0, 1'b1);
    for (int i = 0; i < N_ACT; i++) send(1'b1, i, 0);
    bus.a_in_valid = 1'b0;
    bus.w_in_valid = 1'b0;
    phase_check(1'b1);
    chk("tileA_w_writes", 32'(n_w), 64);
    chk("tileA_a_writes", 32'(n_a), 64);
    chk("tileA_done_count", 32'(n_done), 1);
    // Abort mid LOAD_A after 30 activations
    n_w = 0;
    n_a = 0;
    start_tile();
    load_weights(30, 1'b0);
    for (int i = 0; i < 30; i++) send(1'b1, i, 0);
    rst = 1'b1;
    bus.a_in_valid = 1'b0;
    tick();
    check_zero("mid_rst");
    rst = 1'b0;
    repeat (80) tick();
    chk("rst_no_done", 32'(n_done), 1);
    chk("rst_idle_busy", 32'(bus.busy), 0);
    // Tile B: ~50% bubbles on both channels, must restart at address 0
    n_w = 0;
    n_a = 0;
    start_tile();
    load_weights(50, 1'b0);
    for (int i = 0; i < N_ACT; i++) send(1'b1, i, 50);
    bus.a_in_valid = 1'b0;
    phase_check(1'b0);
    chk("tileB_w_writes", 32'(n_w), 64);
    chk("tileB_a_writes", 32'(n_a), 64);
    chk("tileB_done_count", 32'(n_done), 2);
    chk("ready_overlap", 32'(n_rdy_ovl), 0);
    chk("cal_pcw_overlap", 32'(n_phase_ovl), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
